// File: rtl/demux_1to4_collector_pkg.sv
// Shared definitions for the 1-to-4 steering/collection stage.
// Holds the lane index constants, the FSM state encoding and the width of the fill counter.
// Also holds a popcount helper used to derive word_cnt from the lane-valid mask.
package demux_1to4_collector_pkg;

   localparam logic [1:0] LANE_A = 2'b00;
   localparam logic [1:0] LANE_B = 2'b01;
   localparam logic [1:0] LANE_C = 2'b10;
   localparam logic [1:0] LANE_D = 2'b11;

   localparam int CNT_W = 3;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_FULL = 1'b1
   } state_t;

   function automatic logic [CNT_W-1:0] lane_popcount(input logic [3:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

endpackage

// File: rtl/demux_1to4_collector_lane_reg.sv
// lane_reg: N-bit holding register for one output lane of the collector.
// Ports: clk_i/rst_i (async active-high reset to 0), we_i write enable, d_i data in, q_o held data.
// Latency: written data is visible on q_o one cycle after the enabled edge; no backpressure.
module lane_reg #(
   parameter int N = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         we_i,
   input  logic [N-1:0] d_i,
   output logic [N-1:0] q_o
);

   logic [N-1:0] data_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_q <= '0;
      end else if (we_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/demux_1to4_collector.sv
// demux_1to4_collector: steers single words by slc into four held lanes, emits them as one bundle.
// Ports: in_valid/in_ready/slc/din producer side, clr discard, out_a..out_d/lane_valid/word_cnt/out_valid/out_ready consumer side.
// Latency 1 cycle per word; in_ready low while a full bundle waits for out_ready, clr drops a partial bundle.
module demux_1to4_collector
   import demux_1to4_collector_pkg::*;
#(
   parameter int N = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       slc,
   input  logic [N-1:0]     din,
   input  logic             clr,
   output logic [N-1:0]     out_a,
   output logic [N-1:0]     out_b,
   output logic [N-1:0]     out_c,
   output logic [N-1:0]     out_d,
   output logic [3:0]       lane_valid,
   output logic [CNT_W-1:0] word_cnt,
   output logic             out_valid,
   input  logic             out_ready
);

   state_t           state_q, state_d;
   logic [3:0]       lane_valid_q, lane_valid_d;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

   logic             accept;
   logic [3:0]       lane_sel;
   logic [3:0]       lane_we;

   // Lane enable decoder. clr wins over a same-cycle write, so it masks acceptance.
   always_comb begin
      accept   = in_valid & in_ready & ~clr;
      lane_sel = 4'b0000;
      case (slc)
         LANE_A:  lane_sel = 4'b0001;
         LANE_B:  lane_sel = 4'b0010;
         LANE_C:  lane_sel = 4'b0100;
         LANE_D:  lane_sel = 4'b1000;
         default: lane_sel = 4'b0000;
      endcase
      lane_we = accept ? lane_sel : 4'b0000;
   end

   // State and fill-tracking registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_FILL;
         lane_valid_q <= 4'b0000;
         word_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         lane_valid_q <= lane_valid_d;
         word_cnt_q   <= word_cnt_d;
      end
   end

   // Next-state logic. Rewriting an already-valid lane leaves the mask unchanged,
   // so the bundle completes only when the last missing lane arrives.
   always_comb begin
      state_d      = state_q;
      lane_valid_d = lane_valid_q;
      case (state_q)
         ST_FILL: begin
            if (clr) begin
               lane_valid_d = 4'b0000;
            end else begin
               lane_valid_d = lane_valid_q | lane_we;
               if (lane_valid_d == 4'b1111) begin
                  state_d = ST_FULL;
               end
            end
         end
         ST_FULL: begin
            if (out_ready) begin
               lane_valid_d = 4'b0000;
               state_d      = ST_FILL;
            end
         end
         default: begin
            state_d      = ST_FILL;
            lane_valid_d = 4'b0000;
         end
      endcase
      word_cnt_d = lane_popcount(lane_valid_d);
   end

   // Outputs depend on the registered state only.
   always_comb begin
      in_ready  = (state_q == ST_FILL);
      out_valid = (state_q == ST_FULL);
   end

   assign lane_valid = lane_valid_q;
   assign word_cnt   = word_cnt_q;

   lane_reg #(.N(N)) u_lane_a (.clk_i(clk), .rst_i(rst), .we_i(lane_we[0]), .d_i(din), .q_o(out_a));
   lane_reg #(.N(N)) u_lane_b (.clk_i(clk), .rst_i(rst), .we_i(lane_we[1]), .d_i(din), .q_o(out_b));
   lane_reg #(.N(N)) u_lane_c (.clk_i(clk), .rst_i(rst), .we_i(lane_we[2]), .d_i(din), .q_o(out_c));
   lane_reg #(.N(N)) u_lane_d (.clk_i(clk), .rst_i(rst), .we_i(lane_we[3]), .d_i(din), .q_o(out_d));

endmodule
